// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// The state encoding and index-width helper are used by the FSM and by the storage array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_WIDTH   = 4;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Contents are deliberately left out of reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                        clock,
    input  logic                        we,
    input  logic [idx_width(DEPTH)-1:0] index,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store port: one word written on the commit edge
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
    end

    assign rdata = mem_r[index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts LATENCY-1 wait
// states, commits the access on the edge that enters RESP and holds the response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy
);

    localparam int                   IDX_W  = idx_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAT_M1 = CNT_WIDTH'(LATENCY - 1);

    state_t               state_r, state_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
    logic                 lat_write_r, lat_write_s;
    logic [WIDTH-1:0]     lat_addr_r, lat_addr_s;
    logic [WIDTH-1:0]     lat_wdata_r, lat_wdata_s;
    logic                 rsp_valid_r, busy_r, rsp_err_r, rsp_err_s;
    logic [WIDTH-1:0]     rsp_rdata_r, rsp_rdata_s;
    logic                 req_ready_s, accept_s, commit_s, commit_write_s, commit_oor_s, we_s;
    logic [WIDTH-1:0]     commit_addr_s, commit_wdata_s, mem_rdata_s;

    dmem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_array (
        .clock (clock),
        .we    (we_s),
        .index (commit_addr_s[IDX_W-1:0]),
        .wdata (commit_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state, request latch and access-commit decode
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        lat_write_s    = lat_write_r;
        lat_addr_s     = lat_addr_r;
        lat_wdata_s    = lat_wdata_r;
        commit_s       = 1'b0;
        commit_write_s = lat_write_r;
        commit_addr_s  = lat_addr_r;
        commit_wdata_s = lat_wdata_r;
        req_ready_s    = reset & ((state_r == ST_IDLE) | ((state_r == ST_RESP) & rsp_ready));
        accept_s       = req_valid & req_ready_s;

        case (state_r)
            ST_IDLE: state_s = ST_IDLE;
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // A new request overrides the idle/exit decision; single-cycle latency commits it at once
        if (accept_s) begin
            lat_write_s = req_write;
            lat_addr_s  = req_addr;
            lat_wdata_s = req_wdata;
            cnt_s       = LAT_M1;
            if (LATENCY == 1) begin
                state_s        = ST_RESP;
                commit_s       = 1'b1;
                commit_write_s = req_write;
                commit_addr_s  = req_addr;
                commit_wdata_s = req_wdata;
            end else begin
                state_s = ST_WAIT;
            end
        end else begin
            lat_write_s = lat_write_r;
        end

        commit_oor_s = (IDX_W < WIDTH) ? (|(commit_addr_s >> IDX_W)) : 1'b0;
        we_s         = commit_s & commit_write_s & ~commit_oor_s;

        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        if (commit_s) begin
            rsp_err_s = commit_oor_s;
            if (commit_oor_s) begin
                rsp_rdata_s = '0;
            end else if (commit_write_s) begin
                rsp_rdata_s = commit_wdata_s;
            end else begin
                rsp_rdata_s = mem_rdata_s;
            end
        end else begin
            rsp_err_s = rsp_err_r;
        end
    end

    // State, counter, latched request and response registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            lat_write_r <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            lat_write_r <= lat_write_s;
            lat_addr_r  <= lat_addr_s;
            lat_wdata_r <= lat_wdata_s;
            rsp_valid_r <= (state_s == ST_RESP);
            busy_r      <= (state_s != ST_IDLE);
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH=256): a table of single accesses
// plus hand-written reset, backpressure and back-to-back sequences.
module tb_dmem_responder;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    vec_t vecs [10];

    dmem_responder #(.WIDTH(16), .DEPTH(256), .LATENCY(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full access with rsp_ready held high; checks latency, data and return to idle
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_er);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        check("idle_req_ready", {15'd0, req_ready}, 16'd1);
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 16'hDEAD;
        req_wdata = 16'h0BAD;
        check("wait_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("wait_busy", {15'd0, busy}, 16'd1);
        tick();
        check("resp_valid", {15'd0, rsp_valid}, 16'd1);
        check("resp_rdata", rsp_rdata, exp_rd);
        check("resp_err", {15'd0, rsp_err}, {15'd0, exp_er});
        tick();
        check("after_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("after_busy", {15'd0, busy}, 16'd0);
        check("after_rdata_hold", rsp_rdata, exp_rd);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0000, 16'h1357, 16'h1357, 1'b0};
        vecs[3] = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h1357, 1'b0};
        vecs[6] = '{1'b1, 16'h00FF, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[8] = '{1'b1, 16'h0011, 16'h4242, 16'h4242, 1'b0};
        vecs[9] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b1};

        // Reset held for three cycles
        repeat (3) @(posedge clock);
        #1;
        check("in_reset_req_ready", {15'd0, req_ready}, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rst_req_ready", {15'd0, req_ready}, 16'd1);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_err", {15'd0, rsp_err}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: load held in RESP for three cycles, a stray store must be ignored
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        tick();
        req_valid = 1'b0;
        tick();
        check("bp_valid", {15'd0, rsp_valid}, 16'd1);
        check("bp_rdata", rsp_rdata, 16'hBEEF);
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 16'h0010;
            req_wdata = 16'h9999;
            check("bp_req_ready", {15'd0, req_ready}, 16'd0);
            tick();
            check("bp_hold_valid", {15'd0, rsp_valid}, 16'd1);
            check("bp_hold_rdata", rsp_rdata, 16'hBEEF);
            check("bp_hold_busy", {15'd0, busy}, 16'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", {15'd0, rsp_valid}, 16'd0);
        repeat (3) begin
            tick();
            check("bp_no_second_rsp", {15'd0, rsp_valid}, 16'd0);
        end
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // Back-to-back: new load accepted on the edge that completes the previous response
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        tick();
        req_valid = 1'b0;
        tick();
        check("b2b_first_valid", {15'd0, rsp_valid}, 16'd1);
        check("b2b_first_rdata", rsp_rdata, 16'hBEEF);
        req_valid = 1'b1;
        req_addr  = 16'h0011;
        check("b2b_req_ready", {15'd0, req_ready}, 16'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        check("b2b_gap_valid", {15'd0, rsp_valid}, 16'd0);
        check("b2b_gap_busy", {15'd0, busy}, 16'd1);
        tick();
        check("b2b_second_valid", {15'd0, rsp_valid}, 16'd1);
        check("b2b_second_rdata", rsp_rdata, 16'h4242);
        tick();
        check("b2b_idle", {15'd0, busy}, 16'd0);

        // Reset during WAIT discards an uncommitted store
        access(1'b1, 16'h0020, 16'h5555, 16'h5555, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hAAAA;
        tick();
        req_valid = 1'b0;
        check("mid_wait_busy", {15'd0, busy}, 16'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_busy", {15'd0, busy}, 16'd0);
        check("async_rdata", rsp_rdata, 16'h0000);
        check("async_req_ready", {15'd0, req_ready}, 16'd0);
        check("async_valid", {15'd0, rsp_valid}, 16'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        access(1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
